bsg_wormhole_link_arbiter: RTL
==============================

Name: bsg_wormhole_link_arbiter

Overview:
- Shares one multiplexed wormhole link among num_in_p wormhole sources, e.g. the demux-side inputs feeding a channel tunnel or off-chip link.
- Arbitrates round-robin at packet granularity. Once a header wins, the grant is locked to that input for the header plus len body flits.
- Zero-latency pass-through datapath with no flit storage. Sequencing is done by an FSM, a flit counter and a round-robin pointer.

Parameters:
- width_p, 32: flit width.
- num_in_p, 3: number of requesting inputs (>=2).
- x_cord_width_p, 4: header x-coordinate field width.
- y_cord_width_p, 4: header y-coordinate field width.
- len_width_p, 4: header length field width.
- reserved_width_p, 2: header reserved field width (MSBs).
- max_len_p, 8: largest legal body length; used only by the optional check.
- len_offset_lp (localparam): width_p-reserved_width_p-x_cord_width_p-y_cord_width_p-len_width_p, the LSB of the len field.

Ports:
- clk_i  in  1  clock; all state updates on its rising edge.
- reset_n_i  in  1  reset; one clock; reset is asynchronous and active-low.
- data_i  in  num_in_p*width_p  per-input flit.
- v_i  in  num_in_p  per-input valid.
- yumi_o  out  num_in_p  per-input consume strobe.
- data_o  out  width_p  link flit.
- v_o  out  1  link valid.
- yumi_i  in  1  link consumer accepted data_o this cycle.
- grant_o  out  num_in_p  one-hot current owner; all zero when no owner.
- busy_o  out  1  a packet is locked (state BUSY).
- err_o  out  1  sticky length error (optional feature).

Behaviour:
- Reset (reset_n_i low, asynchronous):
  - state=IDLE, cnt_r=0, last_r=num_in_p-1 so input 0 has first priority, err_r=0.
  - While in reset: v_o=0, yumi_o=0, grant_o=0, busy_o=0, err_o=0.
  - A packet in flight when reset asserts is abandoned. No flit is consumed during reset.
- IDLE:
  - Winner = first i with v_i[i]=1, searching last_r+1, last_r+2, ... modulo num_in_p.
  - No v_i set: v_o=0, grant_o=0, data_o=0.
  - Otherwise: v_o=1, data_o=data_i[winner], grant_o=onehot(winner).
  - All outputs are combinational from v_i/data_i. No latency; yumi_i is permitted to depend on v_o.
- IDLE, on yumi_i with v_o=1:
  - yumi_o[winner]=1 and last_r<=winner.
  - hlen = data_o[len_offset_lp +: len_width_p].
  - hlen==0: single-flit packet; stay IDLE, so next cycle re-arbitrates from winner+1.
  - hlen!=0: state<=BUSY, own_r<=winner, cnt_r<=hlen.
- IDLE, no yumi_i: nothing is consumed and no state changes. The winner may change next cycle if v_i changes; sources are not required to hold v_i.
- BUSY:
  - grant_o=onehot(own_r), v_o=v_i[own_r], data_o=data_i[own_r]. Other inputs never see yumi_o.
  - Bubbles (v_i[own_r]=0) hold the lock: v_o=0 and nothing changes.
  - On yumi_i: yumi_o[own_r]=1 and cnt_r<=cnt_r-1.
  - If cnt_r==1 at that yumi_i: state<=IDLE.
  - Body flits are never parsed for len.
- yumi_i while v_o=0 is illegal. It is ignored: no yumi_o and no state change.
- Invariants:
  - At most one yumi_o bit set per cycle.
  - yumi_o[i]=1 only when grant_o[i]=1 and yumi_i=1.
  - busy_o = (state==BUSY).
- cnt_r is len_width_p bits. An all-ones len gives 2^len_width_p-1 body flits; no wrap is possible since cnt_r stops at 1->IDLE.

Optional Feature:
- Macro BSG_WORMHOLE_LINK_ARBITER_LEN_CHECK_EN.
- Defined: on a header consumed in IDLE with hlen > max_len_p, err_r<=1. err_r clears only on reset and drives err_o. The packet is still forwarded normally.
- Undefined: no comparator is built, err_o is tied 0, and max_len_p is unused.

Test Plan (defaults; len_offset_lp=18):
- Single source, forward and lock:
  - Stimulus: input 1 sends a header with len=3, then 3 bodies; yumi_i always 1.
  - Response: 4 flits out in 4 cycles; grant_o=3'b010 and busy_o=1 for cycles 1-3; IDLE after.
- Round-robin fairness:
  - Stimulus: all inputs continuously present len=0 headers; yumi_i always 1.
  - Response: grant sequence 0,1,2,0,1,2; each input gets exactly one yumi_o per 3 cycles.
- Lock against competition with bubbles:
  - Stimulus: input 0 holds a len=2 packet with a 2-cycle v_i gap between bodies; inputs 1 and 2 are valid throughout.
  - Response: yumi_o[2:1] stays 0 until the second body is consumed; then input 1 wins.
- Link backpressure:
  - Stimulus: yumi_i=0 for 5 cycles mid-packet (cnt_r=2).
  - Response: v_o=1, data_o stable, cnt_r stays 2, no yumi_o; resumes correctly when yumi_i=1.
- Async reset mid-packet:
  - Stimulus: drop reset_n_i between clock edges with cnt_r=2.
  - Response: v_o, yumi_o and busy_o go 0 immediately; after release, input 0 wins first.
- With LEN_CHECK_EN:
  - Stimulus: header with len=12 (>8).
  - Response: packet of 13 flits forwarded; err_o=1 from the next cycle and stays 1 until reset.

Source files
------------

// File: rtl/bsg_wormhole_link_arbiter.sv
// Round-robin, packet-locked arbiter sharing one wormhole link among num_in_p sources.
// Define BSG_WORMHOLE_LINK_ARBITER_LEN_CHECK_EN to build the sticky header-length error flag.
module bsg_wormhole_link_arbiter #(
    parameter int width_p          = 32,
    parameter int num_in_p         = 3,
    parameter int x_cord_width_p   = 4,
    parameter int y_cord_width_p   = 4,
    parameter int len_width_p      = 4,
    parameter int reserved_width_p = 2,
    parameter int max_len_p        = 8
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic [num_in_p*width_p-1:0]  data_i,
    input  logic [num_in_p-1:0]          v_i,
    output logic [num_in_p-1:0]          yumi_o,
    output logic [width_p-1:0]           data_o,
    output logic                         v_o,
    input  logic                         yumi_i,
    output logic [num_in_p-1:0]          grant_o,
    output logic                         busy_o,
    output logic                         err_o
);

    localparam int len_offset_lp = width_p - reserved_width_p - x_cord_width_p
                                   - y_cord_width_p - len_width_p;
    localparam int idx_width_lp  = (num_in_p > 1) ? $clog2(num_in_p) : 1;

    typedef enum logic {IDLE, BUSY} state_e;

    state_e                  state_r;
    logic [idx_width_lp-1:0] last_r;
    logic [idx_width_lp-1:0] own_r;
    logic [len_width_p-1:0]  cnt_r;

    logic [idx_width_lp-1:0] winner;
    logic [idx_width_lp-1:0] sel;
    logic                    found;
    logic                    live;
    logic                    fire;
    logic [len_width_p-1:0]  hlen;

    // Search starts just after the last header winner so every source gets a turn.
    always_comb begin
        int idx;
        idx    = 0;
        found  = 1'b0;
        winner = '0;
        for (int k = 1; k <= num_in_p; k++) begin
            idx = (int'(last_r) + k) % num_in_p;
            if (!found && v_i[idx_width_lp'(idx)]) begin
                found  = 1'b1;
                winner = idx_width_lp'(idx);
            end
        end
    end

    assign sel  = (state_r == BUSY) ? own_r : winner;
    assign live = (state_r == BUSY) || found;
    assign v_o  = reset_n_i && ((state_r == BUSY) ? v_i[own_r] : found);
    assign fire = v_o && yumi_i;

    always_comb begin
        data_o  = '0;
        grant_o = '0;
        for (int i = 0; i < num_in_p; i++) begin
            if (live && (sel == idx_width_lp'(i))) begin
                data_o     = data_i[i*width_p +: width_p];
                grant_o[i] = reset_n_i;
            end
        end
    end

    assign yumi_o = fire ? grant_o : '0;
    assign hlen   = data_o[len_offset_lp +: len_width_p];
    assign busy_o = (state_r == BUSY);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= IDLE;
            last_r  <= idx_width_lp'(num_in_p - 1);
            own_r   <= '0;
            cnt_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (fire) begin
                        last_r <= winner;
                        if (hlen != '0) begin
                            state_r <= BUSY;
                            own_r   <= winner;
                            cnt_r   <= hlen;
                        end
                    end
                end
                BUSY: begin
                    // Body flits only count down; their contents are never parsed.
                    if (fire) begin
                        cnt_r <= cnt_r - 1'b1;
                        if (cnt_r == len_width_p'(1)) begin
                            state_r <= IDLE;
                        end
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

`ifdef BSG_WORMHOLE_LINK_ARBITER_LEN_CHECK_EN
    logic err_r;

    // Oversized headers still pass through; the flag just records that one was seen.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            err_r <= 1'b0;
        end else if (fire && (state_r == IDLE) && (int'(hlen) > max_len_p)) begin
            err_r <= 1'b1;
        end
    end

    assign err_o = err_r;
`else
    assign err_o = 1'b0;
`endif

endmodule
